// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, FSM state constants and defaults for the multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ITER_CNT_W = 6;

    localparam logic [DEF_DATA_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request, move and result signals of the multiply/divide unit.
// MDU_DIV0_FLAG_EN adds the div_zero result flag.
interface mult_div_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] src_a;
    logic [DATA_WIDTH-1:0] src_b;
    logic                  mthi;
    logic                  mtlo;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;
`ifdef MDU_DIV0_FLAG_EN
    logic                  div_zero;
`endif

    modport master (
        output start, op, src_a, src_b, mthi, mtlo, wr_data,
        input  busy, done, hi, lo
`ifdef MDU_DIV0_FLAG_EN
        , input div_zero
`endif
    );

    modport slave (
        input  start, op, src_a, src_b, mthi, mtlo, wr_data,
        output busy, done, hi, lo
`ifdef MDU_DIV0_FLAG_EN
        , output div_zero
`endif
    );

endinterface

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: radix-2 shift-add multiply / restoring divide step on unsigned magnitudes.
// acc_hi:acc_lo holds product halves for multiply, remainder:quotient for divide.
module mdu_iter_core #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic         is_div,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] acc_hi,
    output logic [W-1:0] acc_lo
);
    logic [W-1:0] d;
    logic [W:0]   sum;
    logic [W:0]   sh;
    logic [W-1:0] diff;
    logic         ge;

    always_comb begin
        sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, d} : '0);
        sh   = {acc_hi, acc_lo[W-1]};
        ge   = sh >= {1'b0, d};
        diff = sh[W-1:0] - d;
    end

    // The multiplier (or dividend) sits in acc_lo and is consumed one bit per step.
    always_ff @(posedge clk) begin
        if (rst) begin
            d      <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
        end else if (load) begin
            d      <= is_div ? b : a;
            acc_hi <= '0;
            acc_lo <= is_div ? a : b;
        end else if (step) begin
            acc_hi <= is_div ? (ge ? diff : sh[W-1:0]) : sum[W:1];
            acc_lo <= is_div ? {acc_lo[W-2:0], ge} : {sum[0], acc_lo[W-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU with architectural HI/LO and MTHI/MTLO moves.
// Define MDU_DIV0_FLAG_EN to expose the div_zero result flag.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ITER_CNT_W = DEF_ITER_CNT_W
) (
    input logic            clk,
    input logic            rst,
    mult_div_unit_if.slave bus
);
    localparam int W = DATA_WIDTH;

    logic [1:0]            state;
    logic [ITER_CNT_W-1:0] cnt;
    logic                  op_div;
    logic                  neg_a;
    logic                  neg_b;
    logic                  div0;
    logic [W-1:0]          hi_r;
    logic [W-1:0]          lo_r;
    logic [W-1:0]          acc_hi;
    logic [W-1:0]          acc_lo;
    logic [W-1:0]          a_abs;
    logic [W-1:0]          b_abs;
    logic [W-1:0]          q_fix;
    logic [W-1:0]          r_fix;
    logic [2*W-1:0]        prod_fix;
    logic                  is_div_in;
    logic                  is_signed_in;
    logic                  start_ok;

    // Dividing by zero leaves remainder == |dividend|, so r_fix restores the raw src_a.
    always_comb begin
        is_div_in    = bus.op inside {OP_DIV, OP_DIVU};
        is_signed_in = bus.op inside {OP_MULT, OP_DIV};
        start_ok     = state == IDLE && bus.start;
        a_abs        = is_signed_in && bus.src_a[W-1] ? -bus.src_a : bus.src_a;
        b_abs        = is_signed_in && bus.src_b[W-1] ? -bus.src_b : bus.src_b;
        prod_fix     = neg_a ^ neg_b ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        q_fix        = neg_a ^ neg_b ? -acc_lo : acc_lo;
        r_fix        = neg_a ? -acc_hi : acc_hi;
    end

    mdu_iter_core #(.W(W)) u_core (
        .clk   (clk),
        .rst   (rst),
        .load  (start_ok),
        .step  (state == CALC),
        .is_div(state == IDLE ? is_div_in : op_div),
        .a     (a_abs),
        .b     (b_abs),
        .acc_hi(acc_hi),
        .acc_lo(acc_lo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            op_div <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            div0   <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_div <= is_div_in;
                        neg_a  <= is_signed_in & bus.src_a[W-1];
                        neg_b  <= is_signed_in & bus.src_b[W-1];
                        div0   <= is_div_in && bus.src_b == '0;
                        cnt    <= '0;
                        state  <= CALC;
                    end else begin
                        if (bus.mthi) hi_r <= bus.wr_data;
                        if (bus.mtlo) lo_r <= bus.wr_data;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == ITER_CNT_W'(W - 1)) state <= FIX;
                end
                FIX: begin
                    if (op_div) begin
                        lo_r <= div0 ? DIV0_QUOTIENT : q_fix;
                        hi_r <= r_fix;
                    end else begin
                        {hi_r, lo_r} <= prod_fix;
                    end
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = state == CALC || state == FIX;
    assign bus.done = state == DONE;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
`ifdef MDU_DIV0_FLAG_EN
    assign bus.div_zero = state == DONE && div0;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: random and directed stimulus checked every cycle against a cycle-count model
// built from plain 64-bit arithmetic, plus literal expectations for the documented cases.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mult_div_unit_if #(.DATA_WIDTH(32)) bus ();
    mult_div_unit dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        case (op)
            OP_MULT:  return sa * sb;
            OP_MULTU: return ua * ub;
            OP_DIV:   return b == 0 ? {a, 32'hFFFFFFFF} : {32'(sa % sb), 32'(sa / sb)};
            default:  return b == 0 ? {a, 32'hFFFFFFFF} : {32'(ua % ub), 32'(ua / ub)};
        endcase
    endfunction

    // Model: idle, or counting down the edges until the pending result lands.
    logic [31:0] m_hi = 0, m_lo = 0;
    logic [63:0] m_pend = 0;
    logic        m_pdz = 0, m_done = 0, m_dz = 0, armed = 0;
    int          m_rem = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_hi <= 0; m_lo <= 0; m_rem <= 0; m_done <= 0; m_dz <= 0; armed <= 1;
        end else if (m_done) begin
            m_done <= 0; m_dz <= 0;
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
                {m_hi, m_lo} <= m_pend; m_done <= 1; m_dz <= m_pdz;
            end
        end else if (bus.start) begin
            m_pend <= ref_res(bus.op, bus.src_a, bus.src_b);
            m_pdz  <= bus.op[1] && bus.src_b == 0;
            m_rem  <= 33;
        end else begin
            if (bus.mthi) m_hi <= bus.wr_data;
            if (bus.mtlo) m_lo <= bus.wr_data;
        end
    end

    always @(negedge clk) if (armed) begin
        chk("cyc_busy", bus.busy, m_rem > 0);
        chk("cyc_done", bus.done, m_done);
        chk("cyc_hi", bus.hi, m_hi);
        chk("cyc_lo", bus.lo, m_lo);
`ifdef MDU_DIV0_FLAG_EN
        chk("cyc_div_zero", bus.div_zero, m_dz);
`endif
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int n0, input string name);
        int n = n0;
        while (!bus.done && n < 80) begin
            tick;
            n++;
        end
        chk(name, n, 34);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1; bus.op = op; bus.src_a = a; bus.src_b = b;
        bus.mthi = 1'($urandom_range(0, 1)); bus.mtlo = 1'($urandom_range(0, 1));
        bus.wr_data = $urandom;
        tick;
        bus.start = 0; bus.mthi = 0; bus.mtlo = 0;
        bus.src_a = $urandom; bus.src_b = $urandom;
        wait_done(1, "latency");
    endtask

    task automatic chk_res(input string name, input logic [31:0] h, input logic [31:0] l);
        chk({name, "_hi"}, bus.hi, h);
        chk({name, "_lo"}, bus.lo, l);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 0;
            1: return 1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic seen;
        bus.start = 0; bus.op = 0; bus.src_a = 0; bus.src_b = 0;
        bus.mthi = 0; bus.mtlo = 0; bus.wr_data = 0;
        rst = 1;
        tick; tick;
        rst = 0;
        chk_res("reset", 0, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);

        bus.mthi = 1; bus.wr_data = 32'h12345678;
        tick;
        bus.mthi = 0;
        chk_res("mthi", 32'h12345678, 0);

        run_op(OP_MULT, 32'hFFFFFFFE, 3);   chk_res("mult", 32'hFFFFFFFF, 32'hFFFFFFFA); tick;
        run_op(OP_MULTU, 32'hFFFFFFFE, 3);  chk_res("multu", 2, 32'hFFFFFFFA); tick;
        run_op(OP_DIV, 32'hFFFFFFF9, 2);    chk_res("div", 32'hFFFFFFFF, 32'hFFFFFFFD); tick;
        run_op(OP_DIVU, 32'hFFFFFFF9, 2);   chk_res("divu", 1, 32'h7FFFFFFC); tick;
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF); chk_res("div_ovf", 0, 32'h80000000); tick;
        run_op(OP_DIVU, 5, 0);              chk_res("div0", 5, 32'hFFFFFFFF);
`ifdef MDU_DIV0_FLAG_EN
        chk("div0_flag", bus.div_zero, 1);
`endif
        tick;

        // start + mtlo at cycle 10 of a running MULT: both ignored
        bus.start = 1; bus.op = OP_MULT; bus.src_a = 7; bus.src_b = 32'hFFFFFFFB;
        tick;
        bus.start = 0;
        repeat (9) tick;
        bus.start = 1; bus.op = OP_DIV; bus.mtlo = 1; bus.wr_data = 32'hDEADBEEF;
        tick;
        bus.start = 0; bus.mtlo = 0;
        wait_done(11, "busy_latency");
        chk_res("busy_ign", 32'hFFFFFFFF, 32'hFFFFFFDD);
        tick;
        run_op(OP_MULTU, 6, 7); chk_res("after_done", 0, 42); tick;

        // reset at cycle 20 of a DIV
        bus.start = 1; bus.op = OP_DIV; bus.src_a = 1000; bus.src_b = 7;
        tick;
        bus.start = 0;
        repeat (19) tick;
        rst = 1;
        tick;
        rst = 0;
        chk("abort_busy", bus.busy, 0);
        chk_res("abort", 0, 0);
        seen = 0;
        repeat (20) begin
            tick;
            seen |= bus.done;
        end
        chk("abort_no_done", seen, 0);
        run_op(OP_DIVU, 100, 7); chk_res("post_abort", 2, 14); tick;

        repeat (40) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.mthi = 1'($urandom_range(0, 1)); bus.mtlo = 1'($urandom_range(0, 1));
                bus.wr_data = $urandom;
                tick;
                bus.mthi = 0; bus.mtlo = 0;
            end else begin
                run_op(2'($urandom_range(0, 3)), pick(), pick());
                repeat ($urandom_range(1, 3)) tick;
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
